fft_out_serializer: RTL

- Output-side collector for the 4-lane parallel FFT core (topfft).
- Captures one frame per N/4 cycles on lanes fftOut0_up, fftOut0_down, fftOut1_up, fftOut1_down into a ping-pong buffer.
- Replays the frame one complex sample per cycle on a valid/ready stream for downstream logic (magnitude, DMA, file-dump bench).
- The FFT pipeline cannot stall, so the write side never backpressures; loss is flagged instead.

---
 rtl/fft_out_serializer.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/fft_out_serializer.sv
// Ping-pong collector for the 4-lane FFT output; replays each frame one complex word per cycle on valid/ready.
// Build option: define FFT_OUT_BITREV_EN to bit-reverse the read address (natural-order output).
//
// state    | meaning
// S_IDLE   | waiting for the read bank to become full
// S_FETCH  | memory read of address 0 in flight
// S_STREAM | out_valid high, advancing on each transfer
module fft_out_serializer #(
  parameter int NBITS_out = 19,
  parameter int N         = 128,
  parameter int LOGN      = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic                   in_sof,
  input  logic [2*NBITS_out-1:0] fftOut0_up,
  input  logic [2*NBITS_out-1:0] fftOut0_down,
  input  logic [2*NBITS_out-1:0] fftOut1_up,
  input  logic [2*NBITS_out-1:0] fftOut1_down,
  output logic [2*NBITS_out-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   overflow,
  output logic                   sync_err
);

  localparam int W  = 2*NBITS_out;
  localparam int QW = N/4;
  localparam int BW = LOGN-2;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_STREAM} state_t;

  // One array per lane so a whole beat lands in a single write cycle.
  logic [W-1:0]    r_mem [4][2*QW];

  state_t          r_state;
  logic [1:0]      r_full;
  logic            r_wr_bank;
  logic            r_wr_active;
  logic [BW-1:0]   r_beat;
  logic            r_rd_bank;
  logic [LOGN-1:0] r_rd_addr;

  logic            w_xfer;
  logic            w_last_xfer;
  logic [1:0]      w_free;
  logic [1:0]      w_set;
  logic            w_busy;
  logic            w_sof;
  logic            w_start;
  logic            w_ovf;
  logic            w_cont;
  logic            w_wr_en;
  logic [BW-1:0]   w_wr_beat;
  logic            w_wr_done;
  logic [LOGN-2:0] w_wr_idx;
  logic            w_sel_bank;
  logic [LOGN-1:0] w_sel_addr;
  logic [LOGN-1:0] w_phys;
  logic [W-1:0]    w_rd_word;

  function automatic logic [LOGN-1:0] f_map(input logic [LOGN-1:0] a);
    logic [LOGN-1:0] r;
`ifdef FFT_OUT_BITREV_EN
    for (int i = 0; i < LOGN; i++) r[i] = a[LOGN-1-i];
`else
    r = a;
`endif
    return r;
  endfunction

  assign w_xfer      = (r_state == S_STREAM) && out_ready;
  assign w_last_xfer = w_xfer && (&r_rd_addr);
  assign w_free      = {w_last_xfer & r_rd_bank, w_last_xfer & ~r_rd_bank};

  // A bank freed by the reader this edge may be claimed by a new frame this edge.
  assign w_busy    = r_full[r_wr_bank] && !w_free[r_wr_bank];
  assign w_sof     = in_valid && in_sof;
  assign w_start   = w_sof && !w_busy;
  assign w_ovf     = w_sof && w_busy;
  assign w_cont    = in_valid && !in_sof && r_wr_active;
  assign w_wr_en   = w_start || w_cont;
  assign w_wr_beat = w_start ? '0 : r_beat;
  assign w_wr_done = w_wr_en && (&w_wr_beat);
  assign w_wr_idx  = {r_wr_bank, w_wr_beat};
  assign w_set     = {w_wr_done & r_wr_bank, w_wr_done & ~r_wr_bank};

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[0][w_wr_idx] <= fftOut0_up;
      r_mem[1][w_wr_idx] <= fftOut0_down;
      r_mem[2][w_wr_idx] <= fftOut1_up;
      r_mem[3][w_wr_idx] <= fftOut1_down;
    end
  end

  // Address of the word that out_data will hold after this edge.
  always_comb begin
    w_sel_bank = r_rd_bank;
    w_sel_addr = r_rd_addr + LOGN'(1);
    if (r_state == S_FETCH) begin
      w_sel_addr = '0;
    end else if (w_last_xfer) begin
      w_sel_bank = ~r_rd_bank;
      w_sel_addr = '0;
    end
  end

  assign w_phys    = f_map(w_sel_addr);
  assign w_rd_word = r_mem[w_phys[1:0]][{w_sel_bank, w_phys[LOGN-1:2]}];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_full      <= '0;
      r_wr_bank   <= 1'b0;
      r_wr_active <= 1'b0;
      r_beat      <= '0;
      r_rd_bank   <= 1'b0;
      r_rd_addr   <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      overflow    <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      if (w_sof && r_wr_active) sync_err <= 1'b1;
      if (w_ovf)                overflow <= 1'b1;

      if (w_wr_done) begin
        r_wr_active <= 1'b0;
        r_wr_bank   <= ~r_wr_bank;
        r_beat      <= '0;
      end else if (w_wr_en) begin
        r_wr_active <= 1'b1;
        r_beat      <= w_wr_beat + BW'(1);
      end

      r_full <= (r_full & ~w_free) | w_set;

      case (r_state)
        S_IDLE: begin
          if (r_full[r_rd_bank]) begin
            r_rd_addr <= '0;
            r_state   <= S_FETCH;
          end
        end
        S_FETCH: begin
          out_data  <= w_rd_word;
          out_valid <= 1'b1;
          out_last  <= 1'b0;
          r_state   <= S_STREAM;
        end
        S_STREAM: begin
          if (w_last_xfer) begin
            r_rd_bank <= ~r_rd_bank;
            r_rd_addr <= '0;
            out_last  <= 1'b0;
            if (r_full[~r_rd_bank]) begin
              out_data <= w_rd_word;
            end else begin
              out_valid <= 1'b0;
              r_state   <= S_IDLE;
            end
          end else if (w_xfer) begin
            r_rd_addr <= w_sel_addr;
            out_data  <= w_rd_word;
            out_last  <= &w_sel_addr;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
